// File: rtl/atomic_counter_pkg.sv
// Shared types and constants for the arbitrated two-phase 64-bit counter read.
package atomic_counter_pkg;
  localparam int HW_DEFAULT = 32;
  localparam int CNT_RD_LAT = 1;

  typedef enum logic [2:0] {IDLE, ISSUE, LSB, MSB, RESP} state_e;
endpackage

// File: rtl/atomic_counter_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             any
);

  always_comb begin
    logic [IW-1:0] ci;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    ci    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      ci = IW'((int'(ptr) + i) % N_REQ);
      if (!any && req[ci]) begin
        grant[ci] = 1'b1;
        idx       = ci;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/atomic_counter_arbiter.sv
// Shares one atomic_counter read port between N_REQ requesters, returning
// coherent 64-bit values built from an atomic LSB read plus a snapshot MSB read.
module atomic_counter_arbiter
  import atomic_counter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int HW    = HW_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_REQ-1:0]  rd_req,
  output logic [N_REQ-1:0]  rsp_valid,
  input  logic [N_REQ-1:0]  rsp_ready,
  output logic [2*HW-1:0]   rsp_data,
  output logic              cnt_req,
  output logic              cnt_atomic,
  input  logic              cnt_ack,
  input  logic [HW-1:0]     cnt_count,
  output logic              busy,
  output logic              proto_err
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  gnt_oh_q, gnt_oh_d;
  logic [IW-1:0]     gnt_idx_q, gnt_idx_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [HW-1:0]     lsb_q, lsb_d;
  logic [2*HW-1:0]   rsp_data_q, rsp_data_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic              cnt_req_q, cnt_req_d;
  logic              cnt_atomic_q, cnt_atomic_d;
  logic              proto_err_q, proto_err_d;

  logic [N_REQ-1:0]  arb_grant;
  logic [IW-1:0]     arb_idx;
  logic              arb_any;
  logic              accept;
  logic [HW-1:0]     half_in;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .req   (rd_req),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign accept  = |(rsp_ready & gnt_oh_q);
  // A missing ack yields zero for that half so the sequence never stalls.
  assign half_in = cnt_ack ? cnt_count : '0;

  always_comb begin
    state_d      = state_q;
    gnt_oh_d     = gnt_oh_q;
    gnt_idx_d    = gnt_idx_q;
    ptr_d        = ptr_q;
    lsb_d        = lsb_q;
    rsp_data_d   = rsp_data_q;
    rsp_valid_d  = rsp_valid_q;
    cnt_req_d    = cnt_req_q;
    cnt_atomic_d = cnt_atomic_q;
    proto_err_d  = proto_err_q;

    unique case (state_q)
      IDLE: begin
        if (cnt_ack) proto_err_d = 1'b1;
        if (arb_any) begin
          gnt_oh_d     = arb_grant;
          gnt_idx_d    = arb_idx;
          cnt_req_d    = 1'b1;
          cnt_atomic_d = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt_ack) proto_err_d = 1'b1;
        cnt_req_d    = 1'b1;
        cnt_atomic_d = 1'b0;
        state_d      = LSB;
      end
      LSB: begin
        if (!cnt_ack) proto_err_d = 1'b1;
        lsb_d        = half_in;
        cnt_req_d    = 1'b0;
        cnt_atomic_d = 1'b0;
        state_d      = MSB;
      end
      MSB: begin
        if (!cnt_ack) proto_err_d = 1'b1;
        rsp_data_d  = {half_in, lsb_q};
        rsp_valid_d = gnt_oh_q;
        state_d     = RESP;
      end
      RESP: begin
        if (cnt_ack) proto_err_d = 1'b1;
        if (accept) begin
          rsp_valid_d = '0;
          ptr_d       = gnt_idx_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      gnt_oh_q     <= '0;
      gnt_idx_q    <= '0;
      ptr_q        <= IW'(N_REQ - 1);
      lsb_q        <= '0;
      rsp_data_q   <= '0;
      rsp_valid_q  <= '0;
      cnt_req_q    <= 1'b0;
      cnt_atomic_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_oh_q     <= gnt_oh_d;
      gnt_idx_q    <= gnt_idx_d;
      ptr_q        <= ptr_d;
      lsb_q        <= lsb_d;
      rsp_data_q   <= rsp_data_d;
      rsp_valid_q  <= rsp_valid_d;
      cnt_req_q    <= cnt_req_d;
      cnt_atomic_q <= cnt_atomic_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign cnt_req    = cnt_req_q;
  assign cnt_atomic = cnt_atomic_q;
  assign proto_err  = proto_err_q;
  assign busy       = (state_q != IDLE);

endmodule
